// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared states and memory strobe encodings for the program loader
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    WR_LO,
    WR_HI,
    TERM_LO,
    TERM_HI,
    DONE,
    ERROR
  } state_e;

  localparam logic MEM_SEL   = 1'b0;
  localparam logic MEM_DESEL = 1'b1;
  localparam logic MEM_WRITE = 1'b1;

  localparam logic [15:0] HALT_WORD = 16'hFFFF;

endpackage

// File: rtl/loader_addr_ctr.sv
// rtl/loader_addr_ctr.sv - byte address pointer with load/increment and sticky wrap flag
module loader_addr_ctr #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr,
  output logic              wrap
);

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              wrap_q, wrap_d;

  // wrap stays set once the pointer rolls past the top until the next load
  always_comb begin
    ptr_d  = ptr_q;
    wrap_d = wrap_q;
    if (load) begin
      ptr_d  = load_val;
      wrap_d = 1'b0;
    end else if (inc) begin
      ptr_d = ptr_q + 1'b1;
      if (&ptr_q) wrap_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      wrap_q <= wrap_d;
    end
  end

  assign ptr  = ptr_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot-time byte writer for instruction memory; LOADER_TERM_EN appends halt word 16'hFFFF
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_WORDS = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              word_valid,
  input  logic [15:0]       word_data,
  input  logic              word_last,
  output logic              word_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_cs,
  output logic              mem_wr,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] word_count
);

  localparam logic [ADDR_W-1:0] MAX_CNT = ADDR_W'(MAX_WORDS);

  state_e            state_q, state_d;
  logic [15:0]       word_q, word_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ptr_load, ptr_inc;
  logic [ADDR_W-1:0] ptr;
  logic              wrap;
  logic [15:0]       wr_word;

  loader_addr_ctr #(.ADDR_W(ADDR_W)) u_addr_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ptr_load),
    .load_val (base_addr),
    .inc      (ptr_inc),
    .ptr      (ptr),
    .wrap     (wrap)
  );

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    ptr_load   = 1'b0;
    ptr_inc    = 1'b0;
    word_ready = 1'b0;
    mem_cs     = MEM_DESEL;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_data   = '0;
    wr_word    = (state_q == TERM_LO || state_q == TERM_HI) ? HALT_WORD : word_q;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d  = WAIT;
          ptr_load = 1'b1;
          cnt_d    = '0;
        end
      end
      WAIT: begin
        word_ready = 1'b1;
        if (word_valid) begin
          word_d  = word_data;
          last_d  = word_last;
          state_d = WR_LO;
        end
      end
`ifdef LOADER_TERM_EN
      WR_LO, TERM_LO: begin
`else
      WR_LO: begin
`endif
        // a byte that would land past the top of memory, or a word beyond the limit, is dropped
        if (wrap || cnt_q == MAX_CNT) begin
          state_d = ERROR;
        end else begin
          mem_cs   = MEM_SEL;
          mem_wr   = MEM_WRITE;
          mem_addr = ptr;
          mem_data = wr_word[7:0];
          ptr_inc  = 1'b1;
          state_d  = (state_q == WR_LO) ? WR_HI : TERM_HI;
        end
      end
`ifdef LOADER_TERM_EN
      WR_HI, TERM_HI: begin
`else
      WR_HI: begin
`endif
        if (wrap) begin
          state_d = ERROR;
        end else begin
          mem_cs   = MEM_SEL;
          mem_wr   = MEM_WRITE;
          mem_addr = ptr;
          mem_data = wr_word[15:8];
          ptr_inc  = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (state_q == TERM_HI) begin
            state_d = DONE;
          end else if (last_q) begin
`ifdef LOADER_TERM_EN
            state_d = TERM_LO;
`else
            state_d = DONE;
`endif
          end else begin
            state_d = WAIT;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    done     = (state_q == DONE);
    error    = (state_q == ERROR);
    cpu_hold = !(state_q == IDLE || state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign word_count = cnt_q;

endmodule
